// File: rtl/cv32e40p_pkg.sv
// Shared types for the EX-stage ALU voter.
// Lane bundle layout and voter state encoding.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    VOTE_TMR,
    VOTE_DUPLEX,
    VOTE_FATAL
  } voter_state_e;

  typedef struct packed {
    logic        ready;
    logic        cmp;
    logic [31:0] result;
  } alu_bundle_t;

  // Lowest-index lane not yet retired; lane 0 when none survive.
  function automatic logic [1:0] first_survivor(
    input logic [2:0] retired
  );
    logic [1:0] idx;
    idx = 2'd0;
    if (!retired[0]) idx = 2'd0;
    else if (!retired[1]) idx = 2'd1;
    else if (!retired[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/cv32e40p_alu_lane_monitor.sv
// Per-lane run-length tracker of consecutive
// mismatching compares; flags the retirement point.
module cv32e40p_alu_lane_monitor #(
  parameter int THRESH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic mismatch,
  output logic reached_thresh
);

  localparam int CW = $clog2(THRESH + 1);
  localparam logic [CW-1:0] TH = CW'(THRESH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturating run counter; a clean compare restarts the run.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (mismatch) begin
        if (cnt_q != TH) cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign reached_thresh = enable & mismatch & (cnt_d == TH);

  // Counter register, cleared by reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cv32e40p_alu_voter.sv
// Majority voter for the triplicated ALU with
// lane retirement (TMR -> duplex -> fatal).
import cv32e40p_pkg::*;

module cv32e40p_alu_voter #(
  parameter int WIDTH  = 32,
  parameter int THRESH = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] result_1_i,
  input  logic [WIDTH-1:0] result_2_i,
  input  logic [WIDTH-1:0] result_3_i,
  input  logic             comparison_result_1_i,
  input  logic             comparison_result_2_i,
  input  logic             comparison_result_3_i,
  input  logic             ready_1_i,
  input  logic             ready_2_i,
  input  logic             ready_3_i,
  output logic [WIDTH-1:0] result_o,
  output logic             comparison_result_o,
  output logic             ready_o,
  output logic [2:0]       mismatch_o,
  output logic [2:0]       lane_retired_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int BW = WIDTH + 2;

  logic [BW-1:0] bnd [3];
  logic [BW-1:0] vote;
  logic [BW-1:0] surv;
  logic [BW-1:0] out;

  voter_state_e state_q, state_d;
  logic [2:0] ret_q, ret_d;
  logic [2:0] mm_q, mm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] tmr_mm;
  logic [2:0] dup_mm;
  logic [2:0] cur_mm;
  logic [2:0] reached;
  logic [2:0] alive;
  logic [1:0] sel;
  logic       multi;
  logic       d12, d13, d23;
  logic       mon_en;

  assign bnd[0] = {ready_1_i, comparison_result_1_i, result_1_i};
  assign bnd[1] = {ready_2_i, comparison_result_2_i, result_2_i};
  assign bnd[2] = {ready_3_i, comparison_result_3_i, result_3_i};

  assign vote = (bnd[0] & bnd[1])
              | (bnd[0] & bnd[2])
              | (bnd[1] & bnd[2]);

  assign tmr_mm[0] = bnd[0] != vote;
  assign tmr_mm[1] = bnd[1] != vote;
  assign tmr_mm[2] = bnd[2] != vote;

  assign d12 = bnd[0] != bnd[1];
  assign d13 = bnd[0] != bnd[2];
  assign d23 = bnd[1] != bnd[2];

  // Survivors that disagree with another survivor.
  assign alive = ~ret_q;
  assign dup_mm[0] = alive[0] & ((alive[1] & d12) | (alive[2] & d13));
  assign dup_mm[1] = alive[1] & ((alive[0] & d12) | (alive[2] & d23));
  assign dup_mm[2] = alive[2] & ((alive[0] & d13) | (alive[1] & d23));

  assign cur_mm = (state_q == VOTE_TMR) ? tmr_mm : dup_mm;

  assign mon_en = enable_i & (state_q == VOTE_TMR);

  for (genvar k = 0; k < 3; k++) begin : g_mon
    cv32e40p_alu_lane_monitor #(
      .THRESH(THRESH)
    ) u_mon (
      .clk           (clk),
      .rst           (rst),
      .enable        (mon_en),
      .clear         (clear_i),
      .mismatch      (tmr_mm[k]),
      .reached_thresh(reached[k])
    );
  end

  assign multi = (reached[0] & reached[1])
               | (reached[0] & reached[2])
               | (reached[1] & reached[2]);

  assign sel = first_survivor(ret_q);

  // Pick the lowest surviving lane outside TMR.
  always_comb begin
    unique case (sel)
      2'd1:    surv = bnd[1];
      2'd2:    surv = bnd[2];
      default: surv = bnd[0];
    endcase
  end

  assign out = (state_q == VOTE_TMR) ? vote : surv;

  assign result_o            = out[WIDTH-1:0];
  assign comparison_result_o = out[WIDTH];
  assign ready_o             = out[WIDTH+1];

  // Next state, retirements and status on a compare.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    mm_d    = mm_q;
    cnt_d   = cnt_q;
    if (enable_i) begin
      mm_d = cur_mm;
      if ((|cur_mm) && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        VOTE_TMR: begin
          if (multi) begin
            ret_d   = ret_q | reached;
            state_d = VOTE_FATAL;
          end else if (|reached) begin
            ret_d   = ret_q | reached;
            state_d = VOTE_DUPLEX;
          end
        end
        VOTE_DUPLEX: begin
          if (|dup_mm) state_d = VOTE_FATAL;
        end
        default: state_d = VOTE_FATAL;
      endcase
    end
  end

  // Status registers; reset and clear win.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q <= VOTE_TMR;
      ret_q   <= '0;
      mm_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      mm_q    <= mm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mismatch_o     = mm_q;
  assign lane_retired_o = ret_q;
  assign fatal_o        = state_q == VOTE_FATAL;
  assign err_cnt_o      = cnt_q;

endmodule

// File: tb/tb_cv32e40p_alu_voter.sv
// Self-checking bench for the ALU voter against
// a behavioural lane/vote model.
module tb_cv32e40p_alu_voter;
  import cv32e40p_pkg::*;

  localparam int TH  = 3;
  localparam int CW  = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable_i, clear_i;
  logic [31:0] result_1_i, result_2_i, result_3_i;
  logic comparison_result_1_i, comparison_result_2_i;
  logic comparison_result_3_i;
  logic ready_1_i, ready_2_i, ready_3_i;
  logic [31:0] result_o;
  logic comparison_result_o, ready_o;
  logic [2:0] mismatch_o, lane_retired_o;
  logic fatal_o;
  logic [CW-1:0] err_cnt_o;

  cv32e40p_alu_voter #(
    .WIDTH(32), .THRESH(TH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .enable_i(enable_i), .clear_i(clear_i),
    .result_1_i(result_1_i),
    .result_2_i(result_2_i),
    .result_3_i(result_3_i),
    .comparison_result_1_i(comparison_result_1_i),
    .comparison_result_2_i(comparison_result_2_i),
    .comparison_result_3_i(comparison_result_3_i),
    .ready_1_i(ready_1_i),
    .ready_2_i(ready_2_i),
    .ready_3_i(ready_3_i),
    .result_o(result_o),
    .comparison_result_o(comparison_result_o),
    .ready_o(ready_o),
    .mismatch_o(mismatch_o),
    .lane_retired_o(lane_retired_o),
    .fatal_o(fatal_o),
    .err_cnt_o(err_cnt_o)
  );

  int checks = 0;
  int failures = 0;

  // model: md 0=TMR 1=duplex 2=fatal
  int md;
  int cons [3];
  bit [2:0] ret;
  bit [2:0] mm;
  int ec;
  alu_bundle_t lb [3];

  logic [33:0] obs_out, exp_out;

  function automatic logic [33:0] mk(
    input logic [31:0] r, input bit c, input bit rd);
    return {rd, c, r};
  endfunction

  function automatic logic [33:0] m_vote();
    logic [33:0] v, t;
    int n;
    v = '0;
    for (int i = 0; i < 34; i++) begin
      n = 0;
      for (int k = 0; k < 3; k++) begin
        t = lb[k];
        if (t[i]) n++;
      end
      v[i] = (n >= 2);
    end
    return v;
  endfunction

  function automatic logic [33:0] m_out();
    if (md == 0) return m_vote();
    for (int k = 0; k < 3; k++)
      if (!ret[k]) return lb[k];
    return lb[0];
  endfunction

  task automatic model_step(input bit en, clr, rs);
    logic [33:0] v;
    bit [2:0] n, hitm;
    int hits;
    int sv [$];
    if (rs || clr) begin
      md = 0; ret = 0; mm = 0; ec = 0;
      for (int k = 0; k < 3; k++) cons[k] = 0;
      return;
    end
    if (!en) return;
    n = 0; hitm = 0; hits = 0;
    if (md == 0) begin
      v = m_vote();
      for (int k = 0; k < 3; k++) begin
        n[k] = (lb[k] != v);
        if (n[k]) cons[k] = (cons[k] < TH) ? cons[k] + 1 : TH;
        else cons[k] = 0;
        if (n[k] && cons[k] == TH) begin
          hits++; hitm[k] = 1'b1;
        end
      end
      if (hits == 1) begin ret |= hitm; md = 1; end
      else if (hits >= 2) begin ret |= hitm; md = 2; end
    end else begin
      for (int k = 0; k < 3; k++) if (!ret[k]) sv.push_back(k);
      if (sv.size() == 2 && lb[sv[0]] != lb[sv[1]]) begin
        n[sv[0]] = 1'b1; n[sv[1]] = 1'b1;
      end
      if (md == 1 && n != 0) md = 2;
    end
    mm = n;
    if (n != 0 && ec < MAXC) ec++;
  endtask

  task automatic cycle(input logic [33:0] a, b, c,
                       input bit en, clr, rs);
    lb[0] = a; lb[1] = b; lb[2] = c;
    {ready_1_i, comparison_result_1_i, result_1_i} = a;
    {ready_2_i, comparison_result_2_i, result_2_i} = b;
    {ready_3_i, comparison_result_3_i, result_3_i} = c;
    enable_i = en; clear_i = clr; rst = rs;
    #1;
    obs_out = {ready_o, comparison_result_o, result_o};
    exp_out = m_out();
    @(posedge clk);
    model_step(en, clr, rs);
    #1;
  endtask

  task automatic test_reset();
    logic [33:0] z;
    z = mk(32'h0, 1'b0, 1'b0);
    cycle(z, z, z, 1'b0, 1'b0, 1'b1);
    cycle(z, z, z, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({mismatch_o, lane_retired_o, fatal_o} !== 7'd0) begin
      failures++;
      $display("FAIL reset_status got=%b exp=0",
               {mismatch_o, lane_retired_o, fatal_o});
    end
    checks++;
    if (err_cnt_o !== '0) begin
      failures++;
      $display("FAIL reset_errcnt got=%0d exp=0", err_cnt_o);
    end
  endtask

  task automatic test_match();
    logic [33:0] g;
    g = mk(32'h1234_5678, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(g, g, g, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_out !== g) begin
        failures++;
        $display("FAIL match_out got=%h exp=%h", obs_out, g);
      end
    end
    checks++;
    if (mismatch_o !== 3'b000 || err_cnt_o !== '0 ||
        lane_retired_o !== 3'b000 || fatal_o !== 1'b0) begin
      failures++;
      $display("FAIL match_status got=%b/%0d/%b/%b exp=0",
               mismatch_o, err_cnt_o, lane_retired_o, fatal_o);
    end
  endtask

  task automatic test_glitch();
    logic [33:0] g, e;
    g = mk(32'h1234_5678, 1'b1, 1'b1);
    e = mk(32'h1234_5679, 1'b1, 1'b1);
    cycle(g, e, g, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_out[31:0] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL glitch_out got=%h exp=12345678",
               obs_out[31:0]);
    end
    checks++;
    if (mismatch_o !== 3'b010 || err_cnt_o !== 8'd1) begin
      failures++;
      $display("FAIL glitch_mm got=%b/%0d exp=010/1",
               mismatch_o, err_cnt_o);
    end
    cycle(g, g, g, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mismatch_o !== 3'b000 || err_cnt_o !== 8'd1 ||
        lane_retired_o !== 3'b000) begin
      failures++;
      $display("FAIL glitch_after got=%b/%0d/%b exp=000/1/000",
               mismatch_o, err_cnt_o, lane_retired_o);
    end
  endtask

  task automatic test_retire();
    logic [33:0] g, b, a1, a2;
    g = mk(32'h1234_5678, 1'b1, 1'b1);
    b = mk(32'h1234_5678, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(g, g, b, 1'b1, 1'b0, 1'b0);
      if (i < 2) begin
        cycle(g, g, b, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lane_retired_o !== 3'b000 ||
            mismatch_o !== 3'b100) begin
          failures++;
          $display("FAIL retire_early got=%b/%b exp=000/100",
                   lane_retired_o, mismatch_o);
        end
      end
    end
    checks++;
    if (lane_retired_o !== 3'b100 || fatal_o !== 1'b0 ||
        err_cnt_o !== 8'(ec)) begin
      failures++;
      $display("FAIL retire_lane3 got=%b/%b/%0d exp=100/0/%0d",
               lane_retired_o, fatal_o, err_cnt_o, ec);
    end
    a1 = mk(32'h0000_000A, 1'b0, 1'b1);
    a2 = mk(32'h0000_000B, 1'b1, 1'b0);
    cycle(a1, a2, a2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_out !== a1) begin
      failures++;
      $display("FAIL duplex_follow got=%h exp=%h", obs_out, a1);
    end
  endtask

  task automatic test_duplex_fatal();
    logic [33:0] a, b;
    a = mk(32'hA, 1'b1, 1'b1);
    b = mk(32'hB, 1'b1, 1'b1);
    cycle(a, b, b, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_out[31:0] !== 32'hA) begin
      failures++;
      $display("FAIL dup_out got=%h exp=a", obs_out[31:0]);
    end
    checks++;
    if (fatal_o !== 1'b1 || mismatch_o !== 3'b011) begin
      failures++;
      $display("FAIL dup_fatal got=%b/%b exp=1/011",
               fatal_o, mismatch_o);
    end
    cycle(a, a, b, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fatal_o !== 1'b1 || mismatch_o !== 3'b000) begin
      failures++;
      $display("FAIL fatal_sticky got=%b/%b exp=1/000",
               fatal_o, mismatch_o);
    end
  endtask

  task automatic test_clear(input bit use_rst);
    logic [33:0] x, y;
    x = mk(32'h5555_0000, 1'b0, 1'b1);
    y = mk(32'h0000_AAAA, 1'b1, 1'b0);
    cycle(x, y, x, 1'b1, !use_rst, use_rst);
    checks++;
    if ({mismatch_o, lane_retired_o, fatal_o} !== 7'd0 ||
        err_cnt_o !== '0) begin
      failures++;
      $display("FAIL clear_%0d got=%b/%b/%b/%0d exp=0",
               use_rst, mismatch_o, lane_retired_o,
               fatal_o, err_cnt_o);
    end
    cycle(x, y, y, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_out !== y) begin
      failures++;
      $display("FAIL clear_tmr_%0d got=%h exp=%h",
               use_rst, obs_out, y);
    end
  endtask

  task automatic test_double_retire();
    logic [33:0] a, b, c;
    a = mk(32'h0000_FFFF, 1'b1, 1'b1);
    b = mk(32'hFFFF_0000, 1'b1, 1'b1);
    c = mk(32'h0000_0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(a, b, c, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_out !== c) begin
        failures++;
        $display("FAIL dbl_vote got=%h exp=%h", obs_out, c);
      end
    end
    checks++;
    if (lane_retired_o !== 3'b011 || fatal_o !== 1'b1 ||
        mismatch_o !== 3'b011) begin
      failures++;
      $display("FAIL dbl_retire got=%b/%b/%b exp=011/1/011",
               lane_retired_o, fatal_o, mismatch_o);
    end
    cycle(mk(32'h1, 1'b0, 1'b0), mk(32'h2, 1'b0, 1'b0),
          mk(32'h3, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_out !== mk(32'h3, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL dbl_follow got=%h exp=lane3", obs_out);
    end
  endtask

  task automatic test_no_residual();
    logic [33:0] g, e;
    g = mk(32'hCAFE_0000, 1'b1, 1'b1);
    e = mk(32'hCAFE_0001, 1'b1, 1'b1);
    cycle(e, g, g, 1'b1, 1'b0, 1'b0);
    cycle(e, g, g, 1'b1, 1'b0, 1'b0);
    checks++;
    if (lane_retired_o !== 3'b000 || fatal_o !== 1'b0 ||
        err_cnt_o !== 8'd2) begin
      failures++;
      $display("FAIL residual got=%b/%b/%0d exp=000/0/2",
               lane_retired_o, fatal_o, err_cnt_o);
    end
  endtask

  task automatic test_random();
    logic [33:0] base, l [3];
    bit en, clr, rs;
    for (int i = 0; i < 400; i++) begin
      base = {2'($urandom_range(0, 3)), 32'($urandom)};
      for (int k = 0; k < 3; k++) begin
        l[k] = base;
        if ($urandom_range(0, 3) == 0)
          l[k] = base ^ (34'd1 << $urandom_range(0, 33));
      end
      en  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 39) == 0);
      rs  = ($urandom_range(0, 79) == 0);
      cycle(l[0], l[1], l[2], en, clr, rs);
      checks++;
      if (obs_out !== exp_out) begin
        failures++;
        $display("FAIL rnd_out i=%0d got=%h exp=%h",
                 i, obs_out, exp_out);
      end
      checks++;
      if (mismatch_o !== mm || lane_retired_o !== ret ||
          fatal_o !== (md == 2) || err_cnt_o !== 8'(ec)) begin
        failures++;
        $display("FAIL rnd_stat i=%0d got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 i, mismatch_o, lane_retired_o, fatal_o,
                 err_cnt_o, mm, ret, md == 2, ec);
      end
    end
  endtask

  task automatic test_saturate();
    logic [33:0] g, b, p, q;
    g = mk(32'h0, 1'b0, 1'b1);
    b = mk(32'h0, 1'b0, 1'b0);
    p = mk(32'h1, 1'b0, 1'b1);
    q = mk(32'h2, 1'b0, 1'b1);
    cycle(g, g, g, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(g, g, b, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MAXC + 10; i++)
      cycle(p, q, q, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_cnt_o !== 8'(MAXC) || ec != MAXC) begin
      failures++;
      $display("FAIL sat_cnt got=%0d exp=%0d", err_cnt_o, MAXC);
    end
    checks++;
    if (fatal_o !== 1'b1 || mismatch_o !== 3'b011) begin
      failures++;
      $display("FAIL sat_state got=%b/%b exp=1/011",
               fatal_o, mismatch_o);
    end
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b0; clear_i = 1'b0;
    result_1_i = '0; result_2_i = '0; result_3_i = '0;
    comparison_result_1_i = 1'b0;
    comparison_result_2_i = 1'b0;
    comparison_result_3_i = 1'b0;
    ready_1_i = 1'b0; ready_2_i = 1'b0; ready_3_i = 1'b0;
    md = 0; ret = 0; mm = 0; ec = 0;
    for (int k = 0; k < 3; k++) cons[k] = 0;
    test_reset();
    test_match();
    test_glitch();
    test_retire();
    test_duplex_fatal();
    test_clear(1'b0);
    test_double_retire();
    test_clear(1'b1);
    test_no_residual();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
